// File: rtl/button_debounce_rx.sv
// Push-button receiver: 2-FF synchroniser, prescaled debounce FSM, clean
// level, press/release strobes, press-toggled level and an optional
// long-press strobe.
// Optional feature macro: BUTTON_DEBOUNCE_LONGPRESS_EN (long-press counter
// and outLONG strobe); when undefined outLONG is tied low.
module button_debounce_rx #(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter int unsigned LONG_TICKS     = 1000
) (
  input  logic inCLK,
  input  logic inRESET,
  input  logic inBTN,
  output logic outLEVEL,
  output logic outPRESS,
  output logic outRELEASE,
  output logic outTOGGLE,
  output logic outLONG
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } state_e;

  logic          btn_meta_q, btn_meta_d;
  logic          btn_sync_q, btn_sync_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [SW-1:0] stable_inc;
  state_e        state_q, state_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          toggle_q, toggle_d;
  logic          pressed;
  logic          tick;

  // Synchroniser inputs, pressed normalisation and free-running tick prescaler.
  always_comb begin
    btn_meta_d = inBTN;
    btn_sync_d = btn_meta_q;
    pressed    = btn_sync_q ^ BTN_ACTIVE_LOW;
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    stable_inc = (stable_q == SW'(DEBOUNCE_TICKS)) ? stable_q : stable_q + SW'(1);
  end

  // Debounce FSM: next state, stable-tick counter and registered outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    stable_d  = stable_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    unique case (state_q)
      S_IDLE: begin
        if (pressed) begin
          state_d  = S_PRESS_WAIT;
          stable_d = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!pressed) begin
          state_d  = S_IDLE;
          stable_d = '0;
        end else if (tick) begin
          if (stable_q == SW'(DEBOUNCE_TICKS - 1)) begin
            state_d  = S_PRESSED;
            stable_d = '0;
            level_d  = 1'b1;
            press_d  = 1'b1;
            toggle_d = ~toggle_q;
          end else begin
            stable_d = stable_inc;
          end
        end
      end
      S_PRESSED: begin
        if (!pressed) begin
          state_d  = S_RELEASE_WAIT;
          stable_d = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (pressed) begin
          state_d  = S_PRESSED;
          stable_d = '0;
        end else if (tick) begin
          if (stable_q == SW'(DEBOUNCE_TICKS - 1)) begin
            state_d   = S_IDLE;
            stable_d  = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            stable_d = stable_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; the synchroniser resets to the released pin level.
  always_ff @(posedge inCLK or negedge inRESET) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (!inRESET) begin
      btn_meta_q <= BTN_ACTIVE_LOW;
      btn_sync_q <= BTN_ACTIVE_LOW;
      tick_cnt_q <= '0;
      stable_q   <= '0;
      state_q    <= S_IDLE;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      toggle_q   <= 1'b0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      tick_cnt_q <= tick_cnt_d;
      stable_q   <= stable_d;
      state_q    <= state_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      toggle_q   <= toggle_d;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam int unsigned LW = $clog2(LONG_TICKS + 1);

  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          long_q, long_d;

  // Long-press counter: cleared on press acceptance, counts ticks in PRESSED,
  // holds in RELEASE_WAIT and saturates so it strobes once per press.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (press_d) begin
      long_cnt_d = '0;
    end else if (state_q == S_PRESSED && pressed && tick &&
                 long_cnt_q != LW'(LONG_TICKS)) begin
      long_cnt_d = long_cnt_q + LW'(1);
      long_d     = (long_cnt_q == LW'(LONG_TICKS - 1));
    end
  end

  // Long-press counter and strobe registers.
  always_ff @(posedge inCLK or negedge inRESET) begin
    if (!inRESET) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign outLONG = long_q;
`else
  // Keeps the long-press length referenced when the feature is compiled out.
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_TICKS == 0);
  assign outLONG         = 1'b0;
`endif

  assign outLEVEL   = level_q;
  assign outPRESS   = press_q;
  assign outRELEASE = release_q;
  assign outTOGGLE  = toggle_q;

endmodule

// File: tb/tb_button_debounce_rx.sv
// Self-checking bench for button_debounce_rx with TICK_DIV=4,
// DEBOUNCE_TICKS=3, LONG_TICKS=5, active-low button.
module tb_button_debounce_rx;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int LT = 5;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic inCLK = 1'b0;
  logic inRESET = 1'b0;
  logic inBTN = 1'b1;
  logic outLEVEL, outPRESS, outRELEASE, outTOGGLE, outLONG;

  button_debounce_rx #(
    .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .BTN_ACTIVE_LOW(1'b1), .LONG_TICKS(LT)
  ) dut (
    .inCLK(inCLK), .inRESET(inRESET), .inBTN(inBTN),
    .outLEVEL(outLEVEL), .outPRESS(outPRESS), .outRELEASE(outRELEASE),
    .outTOGGLE(outTOGGLE), .outLONG(outLONG)
  );

  always #5 inCLK = ~inCLK;

  int n_compared = 0;
  int n_mismatch = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_compared++;
    if (act < lo || act > hi) begin
      n_mismatch++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Behavioural model: edge index since reset, pin history, and the rule
  // "a change is accepted once DB ticks have passed while p stayed changed".
  typedef struct packed {
    int n;
    int start;
    int long_cnt;
    bit pin_d1;
    bit pin_d2;
    bit waiting;
    bit level;
    bit toggle;
    bit press;
    bit rel;
    bit lng;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.pin_d1 = 1'b1;
    r.pin_d2 = 1'b1;
    return r;
  endfunction

  function automatic model_t model_step(input model_t s, input logic pin);
    model_t r;
    bit p;
    bit tk;
    r = s;
    r.n = s.n + 1;
    p = (s.pin_d2 == 1'b0);
    tk = (r.n % TD) == 0;
    r.press = 1'b0;
    r.rel = 1'b0;
    r.lng = 1'b0;
    if (!s.waiting) begin
      if (p != s.level) begin
        r.waiting = 1'b1;
        r.start = r.n;
      end else if (s.level && tk && s.long_cnt < LT) begin
        r.long_cnt = s.long_cnt + 1;
        r.lng = LONG_EN && (r.long_cnt == LT);
      end
    end else if (p == s.level) begin
      r.waiting = 1'b0;
    end else if (r.n / TD - s.start / TD >= DB) begin
      r.waiting = 1'b0;
      r.level = !s.level;
      if (r.level) begin
        r.press = 1'b1;
        r.toggle = !s.toggle;
        r.long_cnt = 0;
      end else begin
        r.rel = 1'b1;
      end
    end
    r.pin_d2 = s.pin_d1;
    r.pin_d1 = pin;
    return r;
  endfunction

  model_t m;

  always @(posedge inCLK or negedge inRESET) begin
    if (!inRESET) m <= model_reset();
    else          m <= model_step(m, inBTN);
  end

  always @(posedge inCLK) cyc <= cyc + 1;

  // Compare process: every output against the model on every falling edge.
  always @(negedge inCLK) begin
    check("level", outLEVEL, m.level);
    check("press", outPRESS, m.press);
    check("release", outRELEASE, m.rel);
    check("toggle", outTOGGLE, m.toggle);
    check("long", outLONG, m.lng);
  end

  // Strobe monitor used by the directed literal checks.
  int press_cnt = 0, release_cnt = 0, long_cnt = 0;
  int last_press_cyc = 0, last_release_cyc = 0, last_long_cyc = 0;
  bit tog_hist [16];

  always @(negedge inCLK) begin
    if (outPRESS) begin
      press_cnt <= press_cnt + 1;
      last_press_cyc <= cyc;
      if (press_cnt < 16) tog_hist[press_cnt] <= outTOGGLE;
    end
    if (outRELEASE) begin
      release_cnt <= release_cnt + 1;
      last_release_cyc <= cyc;
    end
    if (outLONG) begin
      long_cnt <= long_cnt + 1;
      last_long_cyc <= cyc;
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge inCLK);
    #1;
  endtask

  initial begin
    int p0, r0, l0, e;

    // Reset values with the pin released and pressed.
    inRESET = 1'b0;
    inBTN = 1'b1;
    cycles(3);
    check("rst_level_btn1", outLEVEL, 1'b0);
    check("rst_toggle_btn1", outTOGGLE, 1'b0);
    check("rst_strobes_btn1", {outPRESS, outRELEASE, outLONG}, 3'b000);
    inBTN = 1'b0;
    cycles(3);
    check("rst_level_btn0", outLEVEL, 1'b0);
    check("rst_strobes_btn0", {outPRESS, outRELEASE, outLONG, outTOGGLE}, 4'b0000);
    inBTN = 1'b1;
    cycles(1);
    inRESET = 1'b1;
    cycles(2);
    check("no_strobe_after_rst", press_cnt + release_cnt + long_cnt, 0);
    cycles(4);

    // Clean press.
    p0 = press_cnt;
    e = cyc;
    inBTN = 1'b0;
    cycles(20);
    check("clean_press_count", press_cnt - p0, 1);
    check_range("clean_press_latency", last_press_cyc - e, 11, 15);
    check("clean_press_level", outLEVEL, 1'b1);
    check("clean_press_toggle", outTOGGLE, 1'b1);

    // Release with a one-cycle low glitch at cycle 3.
    r0 = release_cnt;
    inBTN = 1'b1;
    cycles(3);
    inBTN = 1'b0;
    cycles(1);
    inBTN = 1'b1;
    e = cyc;
    cycles(20);
    check("release_count", release_cnt - r0, 1);
    check_range("release_latency", last_release_cyc - e, 9, 15);
    check("release_toggle_kept", outTOGGLE, 1'b1);
    check("release_level", outLEVEL, 1'b0);

    // Bounce reject: low 6, high 2, low 6, then high.
    p0 = press_cnt;
    inBTN = 1'b0; cycles(6);
    inBTN = 1'b1; cycles(2);
    inBTN = 1'b0; cycles(6);
    inBTN = 1'b1; cycles(20);
    check("bounce_no_press", press_cnt - p0, 0);
    check("bounce_level", outLEVEL, 1'b0);

    // Toggle sequence from a fresh reset: three clean press/release pairs.
    inRESET = 1'b0;
    cycles(2);
    inRESET = 1'b1;
    cycles(4);
    p0 = press_cnt;
    r0 = release_cnt;
    for (int i = 0; i < 3; i++) begin
      inBTN = 1'b0; cycles(20);
      inBTN = 1'b1; cycles(20);
    end
    check("toggle_press_count", press_cnt - p0, 3);
    check("toggle_release_count", release_cnt - r0, 3);
    check("toggle_seq0", tog_hist[p0], 1'b1);
    check("toggle_seq1", tog_hist[p0 + 1], 1'b0);
    check("toggle_seq2", tog_hist[p0 + 2], 1'b1);

    // Reset mid-debounce discards the pending press.
    p0 = press_cnt;
    inBTN = 1'b0;
    cycles(6);
    inRESET = 1'b0;
    inBTN = 1'b1;
    cycles(2);
    inRESET = 1'b1;
    cycles(20);
    check("mid_reset_no_press", press_cnt - p0, 0);
    check("mid_reset_level", outLEVEL, 1'b0);

    // Button held across reset release, then held long.
    p0 = press_cnt;
    l0 = long_cnt;
    inRESET = 1'b0;
    inBTN = 1'b0;
    cycles(3);
    inRESET = 1'b1;
    e = cyc;
    cycles(80);
    check("held_press_count", press_cnt - p0, 1);
    check("held_press_cycle", last_press_cyc - e, 12);
    if (LONG_EN) begin
      check("long_count", long_cnt - l0, 1);
      check_range("long_latency", last_long_cyc - last_press_cyc, 17, 20);
      check("long_exact_delay", last_long_cyc - last_press_cyc, 20);
    end else begin
      check("long_disabled", long_cnt - l0, 0);
    end
    r0 = release_cnt;
    inBTN = 1'b1;
    cycles(20);
    check("held_release_count", release_cnt - r0, 1);
    check("final_level", outLEVEL, 1'b0);
    check("final_long_total", long_cnt - l0, LONG_EN ? 1 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
